// File: rtl/nios_spi_slave_pkg.sv
// Shared constants for the NIOS SPI slave: register map, status bit
// positions, byte width and a helper that assembles the status byte.
package nios_spi_slave_pkg;

  localparam int DATABITS = 8;

  // Register addresses on the CPU bus
  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  // Status bit positions (control enable bits use the same positions)
  localparam int ST_ROE  = 0;
  localparam int ST_TOE  = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_TRDY = 3;
  localparam int ST_RRDY = 4;
  localparam int ST_E    = 5;
  localparam int ST_TUR  = 6;
  localparam int ST_ABT  = 7;

  // Assemble the status byte; E is the OR of all error flags
  function automatic logic [7:0] pack_status(
    input logic abt,
    input logic tur,
    input logic rrdy,
    input logic trdy,
    input logic busy,
    input logic toe,
    input logic roe
  );
    logic [7:0] s;
    s          = '0;
    s[ST_ABT]  = abt;
    s[ST_TUR]  = tur;
    s[ST_E]    = roe | toe | tur | abt;
    s[ST_RRDY] = rrdy;
    s[ST_TRDY] = trdy;
    s[ST_BUSY] = busy;
    s[ST_TOE]  = toe;
    s[ST_ROE]  = roe;
    return s;
  endfunction

endpackage

// File: rtl/nios_spi_slave_if.sv
// CPU-side register bus of the NIOS SPI slave. The CPU (master modport)
// drives address, strobes and write data; the slave returns read data
// and the level interrupt.
interface nios_spi_slave_if;

  logic [2:0]  mem_addr;
  logic        spi_select;
  logic        read_n;
  logic        write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq;

  modport master (
    output mem_addr, spi_select, read_n, write_n, data_from_cpu,
    input  data_to_cpu, irq
  );

  modport slave (
    input  mem_addr, spi_select, read_n, write_n, data_from_cpu,
    output data_to_cpu, irq
  );

endinterface

// File: rtl/nios_spi_slave_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level. RESET_VAL sets
// the idle level the chain (and the edge detector) reset to, so a pin
// that is already away from idle at reset release shows up as an edge.
module nios_spi_slave_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_reg;
  logic              prev_reg;

  // Shift the raw pin through the chain and remember the last synced level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_reg <= {STAGES{RESET_VAL}};
      prev_reg  <= RESET_VAL;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
      prev_reg  <= chain_reg[STAGES-1];
    end
  end

  assign q    = chain_reg[STAGES-1];
  assign rise =  q & ~prev_reg;
  assign fall = ~q &  prev_reg;

endmodule

// File: rtl/nios_spi_slave.sv
// NIOS-style SPI slave, mode CPOL=0/CPHA=1, 8-bit MSB-first frames.
// SCLK/SS_n/MOSI are oversampled by clk through nios_spi_slave_sync.
// Optional feature macro: NIOS_SPI_SLAVE_IRQ_EN enables the control
// register and the maskable level interrupt; without it irq is 0 and
// control reads 0.
module nios_spi_slave
  import nios_spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  nios_spi_slave_if.slave  bus,
  input  logic             SCLK,
  input  logic             SS_n,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_oe
);

  localparam logic [2:0] LAST_BIT = 3'(DATABITS - 1);

  // Synchronized pins and edge pulses
  logic ss_sync, ss_rise, ss_fall;
  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  nios_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset_n(reset_n), .d(SS_n),
    .q(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  nios_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .d(SCLK),
    .q(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  nios_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .d(MOSI),
    .q(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // Datapath and flag registers
  logic [DATABITS-1:0] tx_shift_reg,   tx_shift_next;
  logic [DATABITS-1:0] tx_holding_reg, tx_holding_next;
  logic [DATABITS-1:0] rx_shift_reg,   rx_shift_next;
  logic [DATABITS-1:0] rx_holding_reg, rx_holding_next;
  logic [2:0]          bitcnt_reg,     bitcnt_next;
  logic                rrdy_reg, rrdy_next;
  logic                trdy_reg, trdy_next;
  logic                roe_reg,  roe_next;
  logic                toe_reg,  toe_next;
  logic                tur_reg,  tur_next;
  logic                abt_reg,  abt_next;
  logic                miso_reg, miso_next;
  logic                irq_reg,  irq_next;
  logic [15:0]         data_to_cpu_reg, data_to_cpu_next;
  logic [7:0]          control_reg;
`ifdef NIOS_SPI_SLAVE_IRQ_EN
  logic [7:0]          control_next;
`endif

  // Combinational temporaries
  logic                spi_active;
  logic                rd_strobe, wr_strobe;
  logic                rd_rx, wr_tx, wr_status;
  logic [7:0]          status;
  logic [DATABITS-1:0] rx_byte;
  logic                reload, trdy_mid;
  logic                rrdy_set, roe_set, toe_set, tur_set, abt_set;
  logic                unused_hi;

  assign spi_active = ~ss_sync;
  assign rd_strobe  = bus.spi_select & ~bus.read_n;
  assign wr_strobe  = bus.spi_select & ~bus.write_n;
  assign rd_rx      = rd_strobe & (bus.mem_addr == ADDR_RXDATA);
  assign wr_tx      = wr_strobe & (bus.mem_addr == ADDR_TXDATA);
  assign wr_status  = wr_strobe & (bus.mem_addr == ADDR_STATUS);
  assign unused_hi  = ^bus.data_from_cpu[15:8];

  assign status = pack_status(abt_reg, tur_reg, rrdy_reg, trdy_reg,
                              spi_active, toe_reg, roe_reg);

`ifndef NIOS_SPI_SLAVE_IRQ_EN
  assign control_reg = 8'h00;
`endif

  // Next-state: SPI events first, then the CPU write sees the result
  always_comb begin
    tx_shift_next    = tx_shift_reg;
    tx_holding_next  = tx_holding_reg;
    rx_shift_next    = rx_shift_reg;
    rx_holding_next  = rx_holding_reg;
    bitcnt_next      = bitcnt_reg;
    miso_next        = miso_reg;
    data_to_cpu_next = data_to_cpu_reg;
    rx_byte          = {rx_shift_reg[DATABITS-2:0], mosi_sync};
    reload           = 1'b0;
    rrdy_set         = 1'b0;
    roe_set          = 1'b0;
    toe_set          = 1'b0;
    tur_set          = 1'b0;
    abt_set          = 1'b0;

    if (ss_fall) begin
      bitcnt_next = '0;
      reload      = 1'b1;
    end else if (spi_active && sclk_rise) begin
      miso_next     = tx_shift_reg[DATABITS-1];
      tx_shift_next = {tx_shift_reg[DATABITS-2:0], 1'b0};
    end else if (spi_active && sclk_fall) begin
      rx_shift_next = rx_byte;
      bitcnt_next   = bitcnt_reg + 3'd1;
      if (bitcnt_reg == LAST_BIT) begin
        rx_holding_next = rx_byte;
        rrdy_set        = 1'b1;
        roe_set         = rrdy_reg;
        reload          = 1'b1;
      end
    end else if (ss_rise && (bitcnt_reg != 3'd0)) begin
      bitcnt_next = '0;
      abt_set     = 1'b1;
    end

    // Frame start / byte boundary: take the holding byte or underrun with 0x00
    trdy_mid = trdy_reg;
    if (reload) begin
      if (!trdy_reg) begin
        tx_shift_next = tx_holding_reg;
        trdy_mid      = 1'b1;
      end else begin
        tx_shift_next = '0;
        tur_set       = 1'b1;
      end
    end

    // CPU txdata write evaluated after any same-cycle reload freed the holding
    trdy_next = trdy_mid;
    if (wr_tx) begin
      if (trdy_mid) begin
        tx_holding_next = bus.data_from_cpu[DATABITS-1:0];
        trdy_next       = 1'b0;
      end else begin
        toe_set = 1'b1;
      end
    end

    // Flag sets win over clears
    rrdy_next = (rrdy_reg & ~rd_rx)     | rrdy_set;
    roe_next  = (roe_reg  & ~wr_status) | roe_set;
    toe_next  = (toe_reg  & ~wr_status) | toe_set;
    tur_next  = (tur_reg  & ~wr_status) | tur_set;
    abt_next  = (abt_reg  & ~wr_status) | abt_set;

    // Register reads: one clk latency, held between reads
    if (rd_strobe) begin
      case (bus.mem_addr)
        ADDR_RXDATA:  data_to_cpu_next = {8'h00, rx_holding_reg};
        ADDR_STATUS:  data_to_cpu_next = {8'h00, status};
        ADDR_CONTROL: data_to_cpu_next = {8'h00, control_reg};
        default:      data_to_cpu_next = 16'h0000;
      endcase
    end

`ifdef NIOS_SPI_SLAVE_IRQ_EN
    control_next = control_reg;
    if (wr_strobe && (bus.mem_addr == ADDR_CONTROL))
      control_next = bus.data_from_cpu[7:0];
    irq_next = |(status & control_reg);
`else
    irq_next = 1'b0;
`endif
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift_reg    <= '0;
      tx_holding_reg  <= '0;
      rx_shift_reg    <= '0;
      rx_holding_reg  <= '0;
      bitcnt_reg      <= '0;
      rrdy_reg        <= 1'b0;
      trdy_reg        <= 1'b1;
      roe_reg         <= 1'b0;
      toe_reg         <= 1'b0;
      tur_reg         <= 1'b0;
      abt_reg         <= 1'b0;
      miso_reg        <= 1'b0;
      irq_reg         <= 1'b0;
      data_to_cpu_reg <= '0;
    end else begin
      tx_shift_reg    <= tx_shift_next;
      tx_holding_reg  <= tx_holding_next;
      rx_shift_reg    <= rx_shift_next;
      rx_holding_reg  <= rx_holding_next;
      bitcnt_reg      <= bitcnt_next;
      rrdy_reg        <= rrdy_next;
      trdy_reg        <= trdy_next;
      roe_reg         <= roe_next;
      toe_reg         <= toe_next;
      tur_reg         <= tur_next;
      abt_reg         <= abt_next;
      miso_reg        <= miso_next;
      irq_reg         <= irq_next;
      data_to_cpu_reg <= data_to_cpu_next;
    end
  end

`ifdef NIOS_SPI_SLAVE_IRQ_EN
  // Interrupt enable mask
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) control_reg <= '0;
    else          control_reg <= control_next;
  end
`endif

  assign MISO            = miso_reg;
  assign MISO_oe         = spi_active;
  assign bus.data_to_cpu = data_to_cpu_reg;
  assign bus.irq         = irq_reg;

endmodule

// File: tb/tb_nios_spi_slave.sv
// Self-checking bench for nios_spi_slave: directed scenarios followed by
// randomized CPU/SPI operations, all checked against a byte-level model
// of the register flags and holding buffers.
module tb_nios_spi_slave;
  import nios_spi_slave_pkg::*;

  localparam int HALF = 8;  // SCLK half period in clk cycles (clk/16)

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic SCLK = 1'b0;
  logic SS_n = 1'b1;
  logic MOSI = 1'b0;
  logic MISO, MISO_oe;

  nios_spi_slave_if bus ();

  nios_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe)
  );

  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Byte-level reference model
  logic       m_trdy, m_rrdy, m_roe, m_toe, m_tur, m_abt;
  logic [7:0] m_hold, m_rx, m_ctrl;
  logic [7:0] frame_q[$];

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%04h", tag, got);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {m_abt, m_tur, (m_roe | m_toe | m_tur | m_abt), m_rrdy, m_trdy, 1'b0, m_toe, m_roe};
  endfunction

  task automatic m_reset();
    m_trdy = 1'b1; m_rrdy = 1'b0; m_roe = 1'b0; m_toe = 1'b0;
    m_tur = 1'b0; m_abt = 1'b0; m_hold = 8'h00; m_rx = 8'h00; m_ctrl = 8'h00;
  endtask

  // What the slave transmits next: holding byte if full, else 0x00 with underrun
  task automatic m_load(output logic [7:0] v);
    if (!m_trdy) begin
      v = m_hold;
      m_trdy = 1'b1;
    end else begin
      v = 8'h00;
      m_tur = 1'b1;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus.mem_addr = addr; bus.data_from_cpu = data;
    bus.spi_select = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.spi_select = 1'b0; bus.write_n = 1'b1;
    $display("cpu  write addr=%0d data=0x%04h", addr, data);
    if (addr == ADDR_TXDATA) begin
      if (m_trdy) begin m_hold = data[7:0]; m_trdy = 1'b0; end
      else m_toe = 1'b1;
    end else if (addr == ADDR_STATUS) begin
      m_roe = 1'b0; m_toe = 1'b0; m_tur = 1'b0; m_abt = 1'b0;
    end else if (addr == ADDR_CONTROL) begin
`ifdef NIOS_SPI_SLAVE_IRQ_EN
      m_ctrl = data[7:0];
`else
      m_ctrl = 8'h00;
`endif
    end
  endtask

  task automatic cpu_read(input logic [2:0] addr, output logic [15:0] data);
    @(negedge clk);
    bus.mem_addr = addr; bus.spi_select = 1'b1; bus.read_n = 1'b0;
    @(negedge clk);
    bus.spi_select = 1'b0; bus.read_n = 1'b1;
    data = bus.data_to_cpu;
    $display("cpu  read  addr=%0d data=0x%04h", addr, data);
  endtask

  task automatic read_rx_check(input string tag);
    logic [15:0] d;
    cpu_read(ADDR_RXDATA, d);
    check_val(tag, d, {8'h00, m_rx});
    m_rrdy = 1'b0;
  endtask

  task automatic read_status_check(input string tag);
    logic [15:0] d;
    cpu_read(ADDR_STATUS, d);
    check_val(tag, d, {8'h00, m_status()});
    check_val("irq_level", {15'd0, bus.irq}, {15'd0, |(m_status() & m_ctrl)});
  endtask

  // SPI master: send frame_q bytes in one SS_n frame, then abort_bits extra bits
  task automatic spi_frame(input int abort_bits);
    logic [7:0] load, got, mo;
    int nb;
    nb = frame_q.size();
    SS_n = 1'b0;
    m_load(load);
    wait_clk(HALF);
    check_val("miso_oe_active", {15'd0, MISO_oe}, 16'd1);
    for (int b = 0; b < nb; b++) begin
      mo = frame_q[b];
      got = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        SCLK = 1'b1; MOSI = mo[i];
        wait_clk(HALF);
        got = {got[6:0], MISO};
        SCLK = 1'b0;
        wait_clk(HALF);
      end
      $display("spi  byte mosi=0x%02h miso=0x%02h", mo, got);
      check_val("miso_byte", {8'h00, got}, {8'h00, load});
      if (m_rrdy) m_roe = 1'b1;
      m_rrdy = 1'b1;
      m_rx = mo;
      m_load(load);
    end
    if (abort_bits > 0) begin
      mo = 8'($urandom);
      got = 8'h00;
      for (int i = 0; i < abort_bits; i++) begin
        SCLK = 1'b1; MOSI = mo[7-i];
        wait_clk(HALF);
        got = {got[6:0], MISO};
        SCLK = 1'b0;
        wait_clk(HALF);
      end
      $display("spi  abort after %0d bits miso=0x%02h", abort_bits, got);
      check_val("miso_partial", {8'h00, got}, {8'h00, load >> (8 - abort_bits)});
      m_abt = 1'b1;
    end
    wait_clk(HALF);
    SS_n = 1'b1; MOSI = 1'b0;
    wait_clk(HALF);
    frame_q.delete();
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    int op, nb, ab;
    bus.mem_addr = 3'd0; bus.spi_select = 1'b0; bus.read_n = 1'b1;
    bus.write_n = 1'b1; bus.data_from_cpu = 16'h0000;
    m_reset();

    // Reset values
    wait_clk(3);
    check_val("rst_miso", {15'd0, MISO}, 16'd0);
    check_val("rst_miso_oe", {15'd0, MISO_oe}, 16'd0);
    check_val("rst_irq", {15'd0, bus.irq}, 16'd0);
    check_val("rst_data", bus.data_to_cpu, 16'h0000);
    reset_n = 1'b1;
    wait_clk(4);
    read_status_check("rst_status");

    // txdata 0xA5 out, 0x3C in
    cpu_write(ADDR_TXDATA, 16'h00A5);
    frame_q.push_back(8'h3C);
    spi_frame(0);
    check_val("miso_hold_idle", {15'd0, MISO}, 16'd1);
    check_val("miso_oe_idle", {15'd0, MISO_oe}, 16'd0);
    read_status_check("a5_status_rrdy");
    read_rx_check("a5_rx");
    read_status_check("a5_status_after_read");
    cpu_write(ADDR_STATUS, 16'h0000);

    // Underrun: nothing written
    frame_q.push_back(8'h81);
    spi_frame(0);
    read_status_check("tur_status");
    cpu_write(ADDR_STATUS, 16'hFFFF);
    read_status_check("tur_cleared");
    read_rx_check("tur_rx");

    // Two bytes in one frame without a read -> overrun
    frame_q.push_back(8'h11);
    frame_q.push_back(8'h22);
    spi_frame(0);
    read_rx_check("roe_rx");
    read_status_check("roe_status");
    cpu_write(ADDR_STATUS, 16'h0000);

    // Double txdata write -> TOE, first byte sent
    cpu_write(ADDR_TXDATA, 16'h0055);
    cpu_write(ADDR_TXDATA, 16'h0066);
    read_status_check("toe_status");
    frame_q.push_back(8'h9A);
    spi_frame(0);
    read_rx_check("toe_rx");
    cpu_write(ADDR_STATUS, 16'h0000);

    // Abort after 5 bits, then a good byte
    spi_frame(5);
    read_status_check("abt_status");
    frame_q.push_back(8'hC3);
    spi_frame(0);
    read_rx_check("abt_next_rx");
    cpu_write(ADDR_STATUS, 16'h0000);

    // Interrupt on RRDY
    cpu_write(ADDR_CONTROL, 16'h0010);
    cpu_read(ADDR_CONTROL, d);
    check_val("ctrl_readback", d, {8'h00, m_ctrl});
    frame_q.push_back(8'h5E);
    spi_frame(0);
    check_val("irq_rrdy", {15'd0, bus.irq}, {15'd0, |(m_status() & m_ctrl)});
    read_rx_check("irq_rx");
    check_val("irq_lag", {15'd0, bus.irq}, {15'd0, m_ctrl[ST_RRDY]});
    wait_clk(1);
    check_val("irq_fall", {15'd0, bus.irq}, {15'd0, |(m_status() & m_ctrl)});
    cpu_write(ADDR_STATUS, 16'h0000);

    // Randomized mix
    cpu_write(ADDR_CONTROL, 16'($urandom_range(0, 255)));
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: cpu_write(ADDR_TXDATA, 16'($urandom));
        1: begin
          nb = $urandom_range(0, 2);
          ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
          if (nb == 0 && ab == 0) nb = 1;
          for (int k = 0; k < nb; k++) frame_q.push_back(8'($urandom));
          spi_frame(ab);
        end
        2: read_rx_check("rnd_rx");
        4: cpu_write(ADDR_STATUS, 16'($urandom));
        default: read_status_check("rnd_status");
      endcase
    end
    read_status_check("rnd_final_status");

    // Reset pulsed mid-byte
    SS_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 4; i++) begin
      SCLK = 1'b1; MOSI = 1'b1;
      wait_clk(HALF);
      SCLK = 1'b0;
      wait_clk(HALF);
    end
    reset_n = 1'b0;
    #1;
    check_val("midrst_miso", {15'd0, MISO}, 16'd0);
    check_val("midrst_miso_oe", {15'd0, MISO_oe}, 16'd0);
    check_val("midrst_irq", {15'd0, bus.irq}, 16'd0);
    check_val("midrst_data", bus.data_to_cpu, 16'h0000);
    SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    wait_clk(3);
    reset_n = 1'b1;
    m_reset();
    wait_clk(4);
    read_status_check("midrst_status");
    read_rx_check("midrst_rx");
    cpu_read(ADDR_CONTROL, d);
    check_val("midrst_ctrl", d, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/nios_spi_slave.md
NIOS_SPI_SLAVE -- requirements
Module: nios_spi_slave

Interface
REQ-001 SHALL: parameter SYNC_STAGES, default 2, sets synchronizer depth on SCLK, SS_n and MOSI (legal values 2..3).
REQ-002 SHALL: clk  in  1  system clock; the only clock in the block.
REQ-003 SHALL: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL: mem_addr  in  3  register address (0 rxdata r, 1 txdata w, 2 status r/w, 3 control r/w, others read 0).
REQ-005 SHALL: spi_select, read_n, write_n  in  1 each  bus strobes, active when spi_select=1 and the strobe is low.
REQ-006 SHALL: data_from_cpu  in  16  write data; data_to_cpu  out  16  read data, registered.
REQ-007 SHALL: SCLK, SS_n, MOSI  in  1 each  SPI from an external master; asynchronous to clk.
REQ-008 SHALL: MISO  out  1  serial data; MISO_oe  out  1  high only while synced SS_n is low.
REQ-009 SHALL: irq  out  1  level interrupt, registered.

Function
REQ-010 SHALL: use SPI mode CPOL=0, CPHA=1, 8 data bits, MSB first.
REQ-011 SHALL: sample SCLK, SS_n and MOSI through SYNC_STAGES flops; edges are detected on the synchronized samples.
REQ-012 SHALL: support a minimum SCLK half-period of SYNC_STAGES+2 clk cycles; behaviour under faster SCLK is undefined.
REQ-013 SHALL: load tx_shift on the synced SS_n falling edge:
- with tx_holding if TRDY=0 (holding full), then set TRDY=1;
- otherwise load 0x00 and set TUR.
REQ-014 SHALL: on each synced SCLK rising edge while SS_n is low, drive MISO <= tx_shift[7] and shift tx_shift left by one.
REQ-015 SHALL: on each synced SCLK falling edge while SS_n is low, shift the MOSI sample into rx_shift LSB and increment bitcnt (3 bits).
REQ-016 SHALL: on the 8th falling edge:
- copy rx_shift to rx_holding and set RRDY;
- set ROE if RRDY was already 1 (rx_holding is still overwritten);
- reload tx_shift from tx_holding, or 0x00 with TUR, so back-to-back bytes without an SS_n toggle work.
REQ-017 SHALL: on the synced SS_n rising edge with bitcnt != 0, discard the partial byte, set ABT and clear bitcnt; RRDY is unchanged.
REQ-018 SHALL: on a txdata write:
- with TRDY=1, load tx_holding from data_from_cpu[7:0] and clear TRDY;
- with TRDY=0, set TOE and keep tx_holding unchanged.
REQ-019 SHALL: read latency is one clk; a rxdata read clears RRDY in the same cycle data_to_cpu updates.
REQ-020 SHALL: status = {ABT[7], TUR[6], E[5]=ROE|TOE|TUR|ABT, RRDY[4], TRDY[3], BUSY[2]=~SS_n_sync, TOE[1], ROE[0]}.
REQ-021 SHALL: a status write clears ROE, TOE, TUR and ABT (data ignored), but not RRDY or TRDY.
REQ-022 SHALL: priority on the same clk:
- set beats clear for flags;
- an RRDY set on the 8th edge beats a simultaneous rxdata read clear;
- a tx reload on the 8th edge consumes holding before the same-cycle write is evaluated.
REQ-023 SHALL: MISO holds the last driven bit while SS_n is high; MISO_oe=0.

Reset
REQ-024 SHALL: on reset_n low, asynchronously drive:
- MISO=0, MISO_oe=0, irq=0, data_to_cpu=0;
- rx/tx shifts, holdings, bitcnt and control = 0;
- TRDY=1, all other flags 0;
- synchronizer outputs: SS_n=1, SCLK=0, MOSI=0.
REQ-025 SHALL: treat an SS_n already low at reset release as a falling edge (SS_n synchronizer resets to 1); a transfer already in progress at reset is lost.

Configuration
REQ-026 SHALL: with NIOS_SPI_SLAVE_IRQ_EN defined:
- control[7:0] holds enable bits at the same positions as the status bits;
- irq <= |(status & control) registered, one clk latency.
REQ-027 SHALL: with NIOS_SPI_SLAVE_IRQ_EN undefined, irq is tied 0, control writes are ignored and control reads 0.

Structure
REQ-028 SHALL: package nios_spi_slave_pkg holds the register address constants, status bit index constants and DATABITS=8.
REQ-029 SHALL: a single sub-module, nios_spi_slave_sync, implements the SYNC_STAGES synchronizer plus rise/fall pulse outputs; it is instantiated three times.

Verification
REQ-030 SHALL: write txdata 0xA5, master sends 0x3C at clk/16 -> MISO shifts 10100101, rx reads 0x3C, RRDY 1 then 0 after the read, TRDY=1.
REQ-031 SHALL: no txdata write, master sends one byte -> MISO bits all 0, status TUR=1 and E=1; a status write clears TUR.
REQ-032 SHALL: two bytes 0x11, 0x22 in one SS_n frame, no read between -> rx reads 0x22, ROE=1.
REQ-033 SHALL: two txdata writes 0x55, 0x66 with no transfer -> TOE=1 and the transfer sends 0x55.
REQ-034 SHALL: SS_n raised after 5 bits -> ABT=1, RRDY=0; the next full byte is received correctly.
REQ-035 SHALL: with NIOS_SPI_SLAVE_IRQ_EN, control=0x10 -> irq rises one clk after RRDY and falls one clk after the rxdata read; reset_n pulsed mid-byte -> all outputs return to reset values.
